// File: rtl/mmio_req_pkg.sv
// Shared types and constants for the CCI-P MMIO host requester: FSM states,
// default TID width, mandatory AFU CSR addresses and a saturating-increment helper.
package mmio_req_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    DONE
  } t_mmio_req_state;

  localparam int unsigned TID_W_DEFAULT = 9;

  // Mandatory AFU CSR map, in 32-bit-word units.
  localparam logic [15:0] CSR_DFH      = 16'h0000;
  localparam logic [15:0] CSR_AFU_ID_L = 16'h0002;
  localparam logic [15:0] CSR_AFU_ID_H = 16'h0004;
  localparam logic [15:0] CSR_RSVD0    = 16'h0006;
  localparam logic [15:0] CSR_RSVD1    = 16'h0008;
  localparam logic [15:0] CSR_USER0    = 16'h0020;

  localparam logic [1:0] C0_LEN_64B = 2'b01;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    return (en && (value != '1)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/mmio_req_stats.sv
// Saturating event counters for the MMIO host requester; cleared only by rst.
// Instantiated by mmio_host_requester when MMIO_HOST_REQUESTER_STATS_EN is defined.
module mmio_req_stats
  import mmio_req_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_issue_i,
  input  logic        wr_issue_i,
  input  logic        timeout_i,
  input  logic        stray_i,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
  output logic [31:0] to_cnt_o,
  output logic [31:0] stray_cnt_o
);

  logic [31:0] rd_cnt_q, wr_cnt_q, to_cnt_q, stray_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      to_cnt_q    <= '0;
      stray_cnt_q <= '0;
    end else begin
      rd_cnt_q    <= sat_inc(rd_cnt_q, rd_issue_i);
      wr_cnt_q    <= sat_inc(wr_cnt_q, wr_issue_i);
      to_cnt_q    <= sat_inc(to_cnt_q, timeout_i);
      stray_cnt_q <= sat_inc(stray_cnt_q, stray_i);
    end
  end

  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign to_cnt_o    = to_cnt_q;
  assign stray_cnt_o = stray_cnt_q;

endmodule

// File: rtl/mmio_host_requester.sv
// Host-side CCI-P MMIO initiator: issues c0 MMIO read/write requests, matches c2
// read responses by TID with timeout. Optional stats via MMIO_HOST_REQUESTER_STATS_EN.
module mmio_host_requester
  import mmio_req_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TID_W          = TID_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [15:0]      cmd_addr,
  input  logic [63:0]      cmd_wdata,
  output logic             c0_mmio_wr_valid,
  output logic             c0_mmio_rd_valid,
  output logic [15:0]      c0_address,
  output logic [TID_W-1:0] c0_tid,
  output logic [1:0]       c0_length,
  output logic [63:0]      c0_data,
  input  logic             c2_mmio_rd_valid,
  input  logic [TID_W-1:0] c2_tid,
  input  logic [63:0]      c2_data,
  output logic             rsp_valid,
  output logic [63:0]      rsp_data,
  output logic             rsp_timeout,
  output logic             stray_rsp,
  output logic [31:0]      stat_rd_cnt,
  output logic [31:0]      stat_wr_cnt,
  output logic [31:0]      stat_to_cnt,
  output logic [31:0]      stat_stray_cnt
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  t_mmio_req_state    state_q, state_d;
  logic               write_q, write_d;
  logic [TID_W-1:0]   tid_cnt_q, tid_cnt_d;
  logic [15:0]        to_cnt_q, to_cnt_d;
  logic               wr_valid_q, wr_valid_d;
  logic               rd_valid_q, rd_valid_d;
  logic [15:0]        addr_q, addr_d;
  logic [TID_W-1:0]   tid_q, tid_d;
  logic [1:0]         len_q, len_d;
  logic [63:0]        data_q, data_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic               rsp_to_q, rsp_to_d;
  logic               stray_q, stray_d;
  logic               rsp_hit;

  // tid_q holds the tid of the outstanding read, so it doubles as the match key.
  assign rsp_hit = (state_q == WAIT_RD) && c2_mmio_rd_valid && (c2_tid == tid_q);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d    = state_q;
    write_d    = write_q;
    tid_cnt_d  = tid_cnt_q;
    to_cnt_d   = to_cnt_q;
    wr_valid_d = 1'b0;
    rd_valid_d = 1'b0;
    addr_d     = addr_q;
    tid_d      = tid_q;
    len_d      = len_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_to_d   = 1'b0;
    stray_d    = c2_mmio_rd_valid && !rsp_hit;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          write_d    = cmd_write;
          wr_valid_d = cmd_write;
          rd_valid_d = !cmd_write;
          addr_d     = cmd_addr;
          tid_d      = cmd_write ? '0 : tid_cnt_q;
          len_d      = C0_LEN_64B;
          data_d     = cmd_write ? cmd_wdata : 64'd0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (write_q) begin
          state_d = IDLE;
        end else begin
          tid_cnt_d = tid_cnt_q + TID_W'(1);
          to_cnt_d  = '0;
          state_d   = WAIT_RD;
        end
      end
      WAIT_RD: begin
        to_cnt_d = to_cnt_q + 16'd1;
        // A match on the expiry cycle takes priority over the timeout.
        if (rsp_hit) begin
          rsp_data_d = c2_data;
          state_d    = DONE;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_data_d = '0;
          rsp_to_d   = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      tid_cnt_q  <= '0;
      to_cnt_q   <= '0;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      addr_q     <= '0;
      tid_q      <= '0;
      len_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_to_q   <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      tid_cnt_q  <= tid_cnt_d;
      to_cnt_q   <= to_cnt_d;
      wr_valid_q <= wr_valid_d;
      rd_valid_q <= rd_valid_d;
      addr_q     <= addr_d;
      tid_q      <= tid_d;
      len_q      <= len_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_to_q   <= rsp_to_d;
      stray_q    <= stray_d;
    end
  end

  // Ready is forced low while rst is held so nothing is accepted during reset.
  assign cmd_ready        = (state_q == IDLE) && !rst;
  assign c0_mmio_wr_valid = wr_valid_q;
  assign c0_mmio_rd_valid = rd_valid_q;
  assign c0_address       = addr_q;
  assign c0_tid           = tid_q;
  assign c0_length        = len_q;
  assign c0_data          = data_q;
  assign rsp_valid        = (state_q == DONE);
  assign rsp_data         = rsp_data_q;
  assign rsp_timeout      = rsp_to_q;
  assign stray_rsp        = stray_q;

`ifdef MMIO_HOST_REQUESTER_STATS_EN
  mmio_req_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .rd_issue_i  (rd_valid_q),
    .wr_issue_i  (wr_valid_q),
    .timeout_i   (rsp_to_q),
    .stray_i     (stray_q),
    .rd_cnt_o    (stat_rd_cnt),
    .wr_cnt_o    (stat_wr_cnt),
    .to_cnt_o    (stat_to_cnt),
    .stray_cnt_o (stat_stray_cnt)
  );
`else
  assign stat_rd_cnt    = '0;
  assign stat_wr_cnt    = '0;
  assign stat_to_cnt    = '0;
  assign stat_stray_cnt = '0;
`endif

endmodule

// File: doc/mmio_host_requester.md
Name: mmio_host_requester

Overview:
- Synthesizable MMIO initiator: the host-side end of the CCI-P MMIO path our AFUs respond to.
- Accepts simple read/write commands and drives CCI-P Rx c0 MMIO request signals (mmioWrValid / mmioRdValid, header address/tid, data).
- Collects Tx c2 read responses, matches them by TID and returns data or a timeout indication.
- Used in loopback self-test builds and in simulation to exercise AFU CSR maps without ASE.

Parameters:
- TIMEOUT_CYCLES, 256, cycles to wait for a read response before reporting a timeout; legal range 2..65535.
- TID_W, 9, width of the CCI-P MMIO transaction ID.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = MMIO write, 0 = MMIO read
- cmd_addr  in  16  MMIO address in 32-bit-word units, e.g. 0x0020
- cmd_wdata  in  64  write data
- c0_mmio_wr_valid  out  1  one-cycle write request pulse to AFU
- c0_mmio_rd_valid  out  1  one-cycle read request pulse to AFU
- c0_address  out  16  request header address
- c0_tid  out  TID_W  request header tid
- c0_length  out  2  fixed 2'b01 (64-bit access)
- c0_data  out  64  write data, zero for reads
- c2_mmio_rd_valid  in  1  AFU read response valid
- c2_tid  in  TID_W  response tid
- c2_data  in  64  response data
- rsp_valid  out  1  one-cycle read completion pulse
- rsp_data  out  64  read data, 0 on timeout
- rsp_timeout  out  1  qualifies rsp_valid: no response received
- stray_rsp  out  1  one-cycle pulse: c2 response with unexpected tid or outside WAIT_RD

Behaviour:
- Reset: all outputs 0, except cmd_ready = 0 while rst is asserted and 1 in the first cycle after release; tid counter 0; state IDLE.
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE: cmd_ready = 1. On cmd_valid, latch write/addr/wdata and go to ISSUE. cmd_ready is 0 in every other state.
- ISSUE (exactly one cycle):
  - Assert c0_mmio_wr_valid or c0_mmio_rd_valid together with c0_address, c0_tid and c0_data.
  - Write: go to IDLE. Writes are posted, so no rsp_valid.
  - Read: go to WAIT_RD and clear the timeout counter.
- Valid pulses are registered outputs, asserted the cycle after acceptance. Header/data outputs hold their last value between pulses.
- c0_tid carries the current tid counter for reads and 0 for writes.
- The tid counter increments after each read issue and wraps at 2^TID_W-1 -> 0.
- WAIT_RD: increment the timeout counter each cycle.
  - c2_mmio_rd_valid with c2_tid == issued tid: register c2_data into rsp_data, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no match: rsp_data = 0, rsp_timeout = 1, go to DONE.
  - Matching response in the same cycle as expiry: the response wins, rsp_timeout = 0.
- DONE (one cycle): rsp_valid = 1, then go to IDLE. Read latency from acceptance = 2 + AFU response cycles + 1.
- Stray responses: c2_mmio_rd_valid in any state other than a matching WAIT_RD hit pulses stray_rsp the next cycle and is otherwise ignored. This includes late responses after a timeout.
- Reset mid-operation: the in-flight command is dropped, no rsp_valid, tid returns to 0.

Optional Feature:
- Macro: MMIO_HOST_REQUESTER_STATS_EN.
- Defined: adds 32-bit saturating counters for reads issued, writes issued, timeouts and stray responses.
  - Exposed on extra output ports stat_rd_cnt, stat_wr_cnt, stat_to_cnt, stat_stray_cnt.
  - Cleared by rst only.
- Undefined: those ports are still present and tied to 0. No counter logic is generated.

Decomposition:
- Package mmio_req_pkg contains:
  - state enum t_mmio_req_state;
  - TID_W default;
  - constants for the mandatory CSR addresses: DFH 0x0000, AFU_ID_L 0x0002, AFU_ID_H 0x0004, RSVD 0x0006/0x0008;
  - first user CSR address 0x0020.
- One sub-module, mmio_req_stats, holds the four saturating counters and is instantiated only under the macro.

Test Plan:
- Write cmd addr 0x0020, wdata 0xDEADBEEF_0000_1234 -> c0_mmio_wr_valid for exactly 1 cycle, the cycle after acceptance, with address 0x0020, tid 0, c0_data = wdata. No rsp_valid; cmd_ready is 1 again 2 cycles after acceptance.
- Read addr 0x0000; model AFU replies 3 cycles later with tid 0, data 0x1000_0100_0000_0000 -> rsp_valid 1 cycle with that data, rsp_timeout 0.
- Two back-to-back reads to 0x0002 and 0x0004 -> issued tids 0 and 1. A response carrying tid 5 during the second WAIT_RD -> stray_rsp pulse and continued waiting; the correct tid-1 response then completes.
- Read with TIMEOUT_CYCLES = 8 and no AFU reply -> rsp_valid with rsp_timeout = 1 and rsp_data = 0 exactly at cycle 8 of WAIT_RD. A reply arriving afterwards -> stray_rsp.
- Matching response on the exact expiry cycle -> rsp_timeout = 0, data delivered.
- Assert rst during WAIT_RD -> outputs 0 immediately, no rsp_valid. The next read issues with tid 0. With the stats macro defined, counters read 0 after reset.
